// File: rtl/taxi_sfp_link_mon.sv
// taxi_sfp_link_mon: N-channel SFP+ link monitor (debounced link, LEDs, event statistics).
// Define TAXI_LINK_MON_STAT_EN to build the event counters and the m_axis_stat stream driver.

`default_nettype none

module taxi_sfp_link_mon #(
    parameter int CH                 = 4,
    parameter int DEBOUNCE_CYCLES    = 125000,
    parameter int ACT_STRETCH_CYCLES = 6250000,
    parameter int BLINK_HALF_PERIOD  = 31250000,
    parameter int STAT_ID_BASE       = 0,
    parameter int STAT_ID_W          = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [CH-1:0]            rx_status,
    input  logic [CH-1:0]            rx_act_toggle,
    input  logic [CH-1:0]            tx_act_toggle,
    input  logic [CH-1:0]            sfp_mod_present,
    input  logic [CH-1:0]            sfp_los,
    input  logic [CH-1:0]            sfp_tx_fault,

    output logic [CH-1:0]            link_up,
    output logic [CH-1:0][1:0]       sfp_led,

    output logic [15:0]              m_axis_stat_tdata,
    output logic [STAT_ID_W-1:0]     m_axis_stat_tid,
    output logic [0:0]               m_axis_stat_tuser,
    output logic                     m_axis_stat_tvalid,
    input  logic                     m_axis_stat_tready
);

    localparam logic [1:0] ST_DOWN = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ACT_W = $clog2(ACT_STRETCH_CYCLES + 1);
    localparam int BL_W  = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_STRETCH_CYCLES);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_HALF_PERIOD - 1);

    logic [CH-1:0] rx_m_q, rx_s_q;
    logic [CH-1:0] rxt_m_q, rxt_s_q, rxt_d_q;
    logic [CH-1:0] txt_m_q, txt_s_q, txt_d_q;
    logic [CH-1:0] mod_m_q, mod_s_q;

    logic [1:0]       st_q   [CH];
    logic [1:0]       st_d   [CH];
    logic [DB_W-1:0]  db_q   [CH];
    logic [DB_W-1:0]  db_d   [CH];
    logic [ACT_W-1:0] act_q  [CH];
    logic [ACT_W-1:0] act_d  [CH];

    logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q  <= '0;
            rx_s_q  <= '0;
            rxt_m_q <= '0;
            rxt_s_q <= '0;
            rxt_d_q <= '0;
            txt_m_q <= '0;
            txt_s_q <= '0;
            txt_d_q <= '0;
            mod_m_q <= '0;
            mod_s_q <= '0;
        end else begin
            rx_m_q  <= rx_status;
            rx_s_q  <= rx_m_q;
            rxt_m_q <= rx_act_toggle;
            rxt_s_q <= rxt_m_q;
            rxt_d_q <= rxt_s_q;
            txt_m_q <= tx_act_toggle;
            txt_s_q <= txt_m_q;
            txt_d_q <= txt_s_q;
            mod_m_q <= sfp_mod_present;
            mod_s_q <= mod_m_q;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < CH; n++) begin
            st_d[n] = st_q[n];
            db_d[n] = db_q[n];
            case (st_q[n])
                ST_DOWN: begin
                    if (rx_s_q[n]) begin
                        st_d[n] = ST_QUAL;
                        db_d[n] = '0;
                    end
                end
                ST_QUAL: begin
                    if (!rx_s_q[n]) begin
                        st_d[n] = ST_DOWN;
                    end else if (db_q[n] == DB_LAST) begin
                        st_d[n] = ST_UP;
                    end else begin
                        db_d[n] = db_q[n] + DB_W'(1);
                    end
                end
                ST_UP: begin
                    if (!rx_s_q[n]) begin
                        st_d[n] = ST_DOWN;
                    end
                end
                default: st_d[n] = ST_DOWN;
            endcase

            if ((rxt_s_q[n] ^ rxt_d_q[n]) || (txt_s_q[n] ^ txt_d_q[n])) begin
                act_d[n] = ACT_LOAD;
            end else if (act_q[n] != '0) begin
                act_d[n] = act_q[n] - ACT_W'(1);
            end else begin
                act_d[n] = act_q[n];
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < CH; n++) begin
                st_q[n]  <= ST_DOWN;
                db_q[n]  <= '0;
                act_q[n] <= '0;
            end
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < CH; n++) begin
                st_q[n]  <= st_d[n];
                db_q[n]  <= db_d[n];
                act_q[n] <= act_d[n];
            end
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < CH; n++) begin
            link_up[n]    = (st_q[n] == ST_UP);
            sfp_led[n][0] = (st_q[n] == ST_UP) ? 1'b1 : (mod_s_q[n] & blink_ph_q);
            sfp_led[n][1] = (act_q[n] != '0);
        end
    end

`ifdef TAXI_LINK_MON_STAT_EN

    localparam int NSLOT  = CH * 4;
    localparam int SLOT_W = $clog2(NSLOT);

    logic [CH-1:0] los_m_q, los_s_q, los_d_q;
    logic [CH-1:0] txf_m_q, txf_s_q, txf_d_q;

    logic [NSLOT-1:0]     ev;
    logic [15:0]          pend_q [NSLOT];
    logic [15:0]          pend_d [NSLOT];
    logic [SLOT_W-1:0]    rr_q, rr_d;
    logic [SLOT_W-1:0]    grant_idx;
    logic                 grant_vld;
    logic                 load;

    logic [15:0]          tdata_q, tdata_d;
    logic [STAT_ID_W-1:0] tid_q, tid_d;
    logic                 tvalid_q, tvalid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            los_m_q <= '0;
            los_s_q <= '0;
            los_d_q <= '0;
            txf_m_q <= '0;
            txf_s_q <= '0;
            txf_d_q <= '0;
        end else begin
            los_m_q <= sfp_los;
            los_s_q <= los_m_q;
            los_d_q <= los_s_q;
            txf_m_q <= sfp_tx_fault;
            txf_s_q <= txf_m_q;
            txf_d_q <= txf_s_q;
        end
    end

    // Link events mirror the FSM transitions taken on this same edge.
    always_comb begin
        for (int unsigned n = 0; n < CH; n++) begin
            ev[n*4+0] = (st_q[n] == ST_QUAL) && rx_s_q[n] && (db_q[n] == DB_LAST);
            ev[n*4+1] = (st_q[n] == ST_UP) && !rx_s_q[n];
            ev[n*4+2] = los_s_q[n] & ~los_d_q[n];
            ev[n*4+3] = txf_s_q[n] & ~txf_d_q[n];
        end
    end

    always_comb begin
        int unsigned j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NSLOT; i++) begin
            j = (32'(rr_q) + i) % NSLOT;
            if (!grant_vld && (pend_q[j] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = SLOT_W'(j);
            end
        end
    end

    assign load = !tvalid_q || m_axis_stat_tready;

    // A same-cycle event on the granted slot restarts it at 1 rather than being lost.
    always_comb begin
        for (int unsigned s = 0; s < NSLOT; s++) begin
            pend_d[s] = pend_q[s];
            if (load && grant_vld && (grant_idx == SLOT_W'(s))) begin
                pend_d[s] = ev[s] ? 16'd1 : 16'd0;
            end else if (ev[s] && (pend_q[s] != '1)) begin
                pend_d[s] = pend_q[s] + 16'd1;
            end
        end

        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        rr_d     = rr_q;
        if (load) begin
            tvalid_d = grant_vld;
            if (grant_vld) begin
                tdata_d = pend_q[grant_idx];
                tid_d   = STAT_ID_W'(STAT_ID_BASE + int'(grant_idx));
                rr_d    = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSLOT; s++) begin
                pend_q[s] <= '0;
            end
            rr_q     <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tid_q    <= '0;
        end else begin
            for (int unsigned s = 0; s < NSLOT; s++) begin
                pend_q[s] <= pend_d[s];
            end
            rr_q     <= rr_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
        end
    end

    assign m_axis_stat_tdata  = tdata_q;
    assign m_axis_stat_tid    = tid_q;
    assign m_axis_stat_tuser  = 1'b0;
    assign m_axis_stat_tvalid = tvalid_q;

`else

    logic        unused_stat_in;
    logic [31:0] unused_id_base;

    assign unused_stat_in = ^{sfp_los, sfp_tx_fault, m_axis_stat_tready};
    assign unused_id_base = STAT_ID_BASE;

    assign m_axis_stat_tdata  = '0;
    assign m_axis_stat_tid    = '0;
    assign m_axis_stat_tuser  = 1'b0;
    assign m_axis_stat_tvalid = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_taxi_sfp_link_mon.sv
// Testbench for taxi_sfp_link_mon: link debounce, LEDs, and the statistics stream via a scoreboard.
`timescale 1ns/1ps

module tb_taxi_sfp_link_mon;

    localparam int CH    = 4;
    localparam int DB    = 8;
    localparam int ACT   = 4;
    localparam int BLINK = 6;

`ifdef TAXI_LINK_MON_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [CH-1:0]      rx_status = '0;
    logic [CH-1:0]      rx_act_toggle = '0;
    logic [CH-1:0]      tx_act_toggle = '0;
    logic [CH-1:0]      sfp_mod_present = '0;
    logic [CH-1:0]      sfp_los = '0;
    logic [CH-1:0]      sfp_tx_fault = '0;
    logic [CH-1:0]      link_up;
    logic [CH-1:0][1:0] sfp_led;
    logic [15:0]        tdata;
    logic [9:0]         tid;
    logic [0:0]         tuser;
    logic               tvalid;
    logic               tready = 1'b1;

    taxi_sfp_link_mon #(
        .CH                 (CH),
        .DEBOUNCE_CYCLES    (DB),
        .ACT_STRETCH_CYCLES (ACT),
        .BLINK_HALF_PERIOD  (BLINK),
        .STAT_ID_BASE       (0),
        .STAT_ID_W          (10)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_status          (rx_status),
        .rx_act_toggle      (rx_act_toggle),
        .tx_act_toggle      (tx_act_toggle),
        .sfp_mod_present    (sfp_mod_present),
        .sfp_los            (sfp_los),
        .sfp_tx_fault       (sfp_tx_fault),
        .link_up            (link_up),
        .sfp_led            (sfp_led),
        .m_axis_stat_tdata  (tdata),
        .m_axis_stat_tid    (tid),
        .m_axis_stat_tuser  (tuser),
        .m_axis_stat_tvalid (tvalid),
        .m_axis_stat_tready (tready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [9:0]  tid;
        logic [15:0] data;
    } beat_t;

    beat_t sb[$];
    beat_t mon_exp;

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [15:0] pd = '0;
    logic [9:0]  pt = '0;

    // Stream monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && !pr) begin
                n_cmp++;
                if (tvalid !== 1'b1 || tdata !== pd || tid !== pt) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b tid=%0d data=%0d, required v=1 tid=%0d data=%0d",
                             tvalid, tid, tdata, pt, pd);
                end
            end
            if (tvalid && tready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got tid=%0d data=%0d, required no beat", tid, tdata);
                end else begin
                    mon_exp = sb.pop_front();
                    if (tid !== mon_exp.tid || tdata !== mon_exp.data || tuser !== 1'b0) begin
                        n_fail++;
                        $display("FAIL beat: got tid=%0d data=%0d user=%0b, required tid=%0d data=%0d user=0",
                                 tid, tdata, tuser, mon_exp.tid, mon_exp.data);
                    end
                end
            end
        end
        pv = rst_n && tvalid;
        pr = tready;
        pd = tdata;
        pt = tid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int t, input int d);
        beat_t b;
        b.tid  = 10'(t);
        b.data = 16'(d);
        if (STAT_EN) sb.push_back(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (link_up !== '0 || sfp_led !== '0) begin
            n_fail++;
            $display("FAIL reset_leds: got link=%b led=%b, required 0/0", link_up, sfp_led);
        end
        n_cmp++;
        if (tvalid !== 1'b0 || tdata !== '0 || tid !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: got v=%0b tid=%0d data=%0d, required all 0", tvalid, tid, tdata);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (link_up !== '0 || sfp_led !== '0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got link=%b led=%b v=%0b, required 0", link_up, sfp_led, tvalid);
        end
    endtask

    task automatic test_link_up();
        rx_status[0] = 1'b1;
        push(0, 1);
        for (int e = 0; e <= 12; e++) begin
            tick();
            n_cmp++;
            if (link_up[0] !== (e >= 10)) begin
                n_fail++;
                $display("FAIL link0_rise edge %0d: got %0b, required %0b", e, link_up[0], (e >= 10));
            end
            if (e == 11) begin
                n_cmp++;
                if (tvalid !== STAT_EN || tdata !== (STAT_EN ? 16'd1 : 16'd0)) begin
                    n_fail++;
                    $display("FAIL link0_beat_latency: got v=%0b data=%0d, required v=%0b", tvalid, tdata, STAT_EN);
                end
            end
        end
        n_cmp++;
        if (sfp_led[0][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL link0_led: got %0b, required 1", sfp_led[0][0]);
        end
        rx_status[0] = 1'b0;
        push(1, 1);
        for (int e = 0; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (link_up[0] !== (e < 2)) begin
                n_fail++;
                $display("FAIL link0_fall edge %0d: got %0b, required %0b", e, link_up[0], (e < 2));
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL link0_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_debounce_abort();
        rx_status[1] = 1'b1;
        repeat (5) tick();
        rx_status[1] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            tick();
            n_cmp++;
            if (link_up[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL link1_abort cycle %0d: got %0b, required 0", e, link_up[1]);
            end
        end
        rx_status[1] = 1'b1;
        push(4, 1);
        for (int e = 0; e <= 12; e++) begin
            tick();
            n_cmp++;
            if (link_up[1] !== (e >= 10)) begin
                n_fail++;
                $display("FAIL link1_rise edge %0d: got %0b, required %0b", e, link_up[1], (e >= 10));
            end
        end
        rx_status[1] = 1'b0;
        push(5, 1);
        for (int e = 0; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (link_up[1] !== (e < 2)) begin
                n_fail++;
                $display("FAIL link1_fall edge %0d: got %0b, required %0b", e, link_up[1], (e < 2));
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL link1_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        tready = 1'b0;
        sfp_los[0] = 1'b1;
        push(2, 1);
        repeat (3) tick();
        sfp_los[0] = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (tvalid !== STAT_EN || tid !== (STAT_EN ? 10'd2 : 10'd0) || tdata !== (STAT_EN ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL bp_first_held: got v=%0b tid=%0d data=%0d", tvalid, tid, tdata);
        end
        for (int k = 0; k < 3; k++) begin
            sfp_los[2] = 1'b1;
            repeat (3) tick();
            sfp_los[2] = 1'b0;
            repeat (3) tick();
        end
        push(10, 3);
        repeat (3) tick();
        n_cmp++;
        if (tvalid !== STAT_EN || tid !== (STAT_EN ? 10'd2 : 10'd0)) begin
            n_fail++;
            $display("FAIL bp_still_held: got v=%0b tid=%0d", tvalid, tid);
        end
        tready = 1'b1;
        tick();
        n_cmp++;
        if (tvalid !== STAT_EN || tid !== (STAT_EN ? 10'd10 : 10'd0) || tdata !== (STAT_EN ? 16'd3 : 16'd0)) begin
            n_fail++;
            $display("FAIL bp_coalesced: got v=%0b tid=%0d data=%0d, required tid=10 data=3", tvalid, tid, tdata);
        end
        tick();
        n_cmp++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got v=%0b, required 0", tvalid);
        end
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic       ev;
        logic [9:0] et;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        sfp_tx_fault[0] = 1'b1;
        sfp_tx_fault[3] = 1'b1;
        push(3, 1);
        push(15, 1);
        for (int e = 0; e <= 5; e++) begin
            tick();
            ev = STAT_EN && (e == 3 || e == 4);
            et = !STAT_EN ? 10'd0 : (e < 3) ? 10'd0 : (e == 3) ? 10'd3 : 10'd15;
            n_cmp++;
            if (tvalid !== ev || tid !== et || (ev && tdata !== 16'd1)) begin
                n_fail++;
                $display("FAIL rr edge %0d: got v=%0b tid=%0d data=%0d, required v=%0b tid=%0d data=1",
                         e, tvalid, tid, tdata, ev, et);
            end
        end
        sfp_tx_fault = '0;
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_activity();
        logic prev;
        logic cur;
        logic found;
        rx_act_toggle[0] = ~rx_act_toggle[0];
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (sfp_led[0][1] !== (e >= 2 && e <= 5)) begin
                n_fail++;
                $display("FAIL act0 edge %0d: got %0b, required %0b", e, sfp_led[0][1], (e >= 2 && e <= 5));
            end
        end
        tx_act_toggle[2] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            n_cmp++;
            if (sfp_led[2][1] !== (e >= 2 && e <= 5)) begin
                n_fail++;
                $display("FAIL act2_tx edge %0d: got %0b, required %0b", e, sfp_led[2][1], (e >= 2 && e <= 5));
            end
        end
        sfp_mod_present[1] = 1'b1;
        repeat (3) tick();
        prev  = sfp_led[1][0];
        found = 1'b0;
        for (int k = 0; k < 2 * BLINK + 2 && !found; k++) begin
            tick();
            if (sfp_led[1][0] !== prev) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL blink_start: got no toggle, required a toggle within %0d cycles", 2 * BLINK + 2);
        end
        cur = sfp_led[1][0];
        for (int k = 1; k <= BLINK; k++) begin
            tick();
            n_cmp++;
            if (sfp_led[1][0] !== ((k < BLINK) ? cur : ~cur)) begin
                n_fail++;
                $display("FAIL blink cycle %0d: got %0b, required %0b", k, sfp_led[1][0], ((k < BLINK) ? cur : ~cur));
            end
        end
        n_cmp++;
        if (sfp_led[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL link_led_absent: got %0b, required 0", sfp_led[0][0]);
        end
        sfp_mod_present[1] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        tready = 1'b0;
        rx_status[2] = 1'b1;
        sfp_tx_fault[1] = 1'b1;
        sfp_mod_present[0] = 1'b1;
        rx_act_toggle[3] = 1'b1;
        repeat (10) tick();
        rx_act_toggle[3] = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (link_up[2] !== 1'b1 || sfp_led[3][1] !== 1'b1 || tvalid !== STAT_EN) begin
            n_fail++;
            $display("FAIL pre_reset_busy: got link2=%0b act3=%0b v=%0b, required 1/1/%0b",
                     link_up[2], sfp_led[3][1], tvalid, STAT_EN);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (link_up !== '0 || sfp_led !== '0) begin
            n_fail++;
            $display("FAIL async_reset_leds: got link=%b led=%b, required 0", link_up, sfp_led);
        end
        n_cmp++;
        if (tvalid !== 1'b0 || tdata !== '0 || tid !== '0) begin
            n_fail++;
            $display("FAIL async_reset_stream: got v=%0b tid=%0d data=%0d, required 0", tvalid, tid, tdata);
        end
        rx_status       = '0;
        sfp_tx_fault    = '0;
        sfp_mod_present = '0;
        repeat (2) tick();
        rst_n  = 1'b1;
        tready = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (tvalid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got v=%0b queue=%0d, required 0/0", tvalid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_debounce_abort();
        test_backpressure();
        test_round_robin();
        test_activity();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
